// File: rtl/voice_allocator.sv
// voice_allocator
//   Assigns incoming note-on/note-off commands to one of NUM_VOICES generator
//   slots and forwards the decision to the bank manager over a valid/ready link.
//   Each accepted command is scanned against the slot table, one slot per
//   cycle. A note-on goes to the slot already playing that note (retrigger),
//   else to the lowest free slot, else to the oldest active slot. A note-off
//   goes to the first active slot playing that note.
//
//   Build option: VOICE_STEAL_EN
//     defined   - a note-on with no matching or free slot steals the oldest slot
//     undefined - such a note-on is discarded and o_drop pulses for one cycle
//
//   Ports
//     clk          system clock, rising edge
//     n_rst        asynchronous active-low reset
//     i_cmd_valid  command present
//     i_cmd_data   [15] 1=note-on/0=note-off, [13:7] velocity, [6:0] note
//     o_cmd_ready  high only while idle; command taken when valid && ready
//     o_slot_valid slot command to the bank manager
//     i_slot_ready bank manager takes the slot command
//     o_slot_idx   target slot
//     o_slot_data  latched command word; bit 15 is the gate
//     o_active     per-slot gate mask
//     o_drop       one-cycle pulse when a note-on is discarded
//
//   state | meaning
//   IDLE  | waiting for a command, o_cmd_ready high
//   SCAN  | walking the slot table, one slot per cycle
//   ISSUE | presenting the slot command until i_slot_ready
module voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int IDX_W      = 3
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_cmd_valid,
    input  logic [15:0]           i_cmd_data,
    output logic                  o_cmd_ready,
    output logic                  o_slot_valid,
    input  logic                  i_slot_ready,
    output logic [IDX_W-1:0]      o_slot_idx,
    output logic [15:0]           o_slot_data,
    output logic [NUM_VOICES-1:0] o_active,
    output logic                  o_drop
);

    typedef enum logic [1:0] {IDLE, SCAN, ISSUE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [IDX_W-1:0] AGE_MAX  = IDX_W'(NUM_VOICES - 1);

    state_t state_q, state_d;

    logic [15:0]           cmd_q;
    logic [IDX_W-1:0]      scan_idx;
    logic [NUM_VOICES-1:0] gate_tab;
    logic [6:0]            note_tab [NUM_VOICES];
    logic [IDX_W-1:0]      age_tab  [NUM_VOICES];

    // running scan results for slots already examined
    logic             match_found, free_found, old_found;
    logic [IDX_W-1:0] match_idx, free_idx, old_idx, old_age;

    // scan results including the slot examined this cycle
    logic             cur_gate, cur_match, take_old;
    logic             m_found_c, f_found_c, o_found_c;
    logic [IDX_W-1:0] m_idx_c, f_idx_c, o_idx_c, o_age_c;
    logic             last_slot, issue_c, drop_c;
    logic [IDX_W-1:0] sel_c;

    logic             sel_new;
    logic [IDX_W-1:0] sel_age;

    assign cur_gate  = gate_tab[scan_idx];
    assign cur_match = cur_gate && (note_tab[scan_idx] == cmd_q[6:0]);
    assign take_old  = cur_gate && (!old_found || (age_tab[scan_idx] > old_age));

    assign m_found_c = match_found | cur_match;
    assign m_idx_c   = match_found ? match_idx : scan_idx;
    assign f_found_c = free_found | ~cur_gate;
    assign f_idx_c   = free_found ? free_idx : scan_idx;
    assign o_found_c = old_found | cur_gate;
    assign o_idx_c   = take_old ? scan_idx : old_idx;
    assign o_age_c   = take_old ? age_tab[scan_idx] : old_age;
    assign last_slot = (scan_idx == LAST_IDX);

    // table state of the chosen slot, stable throughout ISSUE
    assign sel_new = ~gate_tab[o_slot_idx];
    assign sel_age = age_tab[o_slot_idx];

    assign o_cmd_ready  = (state_q == IDLE);
    assign o_slot_valid = (state_q == ISSUE);
    assign o_active     = gate_tab;

    // slot choice; only consumed on the last scan cycle
    always_comb begin
        issue_c = 1'b0;
        drop_c  = 1'b0;
        sel_c   = '0;
        if (cmd_q[15]) begin
            if (m_found_c) begin
                issue_c = 1'b1;
                sel_c   = m_idx_c;
            end else if (f_found_c) begin
                issue_c = 1'b1;
                sel_c   = f_idx_c;
            end else begin
`ifdef VOICE_STEAL_EN
                issue_c = 1'b1;
                sel_c   = o_idx_c;
`else
                drop_c  = 1'b1;
`endif
            end
        end else if (m_found_c) begin
            issue_c = 1'b1;
            sel_c   = m_idx_c;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_cmd_valid) state_d = SCAN;
            SCAN:    if (last_slot) state_d = issue_c ? ISSUE : IDLE;
            ISSUE:   if (i_slot_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cmd_q       <= '0;
            scan_idx    <= '0;
            gate_tab    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            old_idx     <= '0;
            old_age     <= '0;
            o_slot_idx  <= '0;
            o_slot_data <= '0;
            o_drop      <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_tab[i] <= '0;
                age_tab[i]  <= '0;
            end
        end else begin
            o_drop <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_cmd_valid) begin
                        cmd_q       <= i_cmd_data;
                        scan_idx    <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        old_found   <= 1'b0;
                    end
                end
                SCAN: begin
                    match_found <= m_found_c;
                    match_idx   <= m_idx_c;
                    free_found  <= f_found_c;
                    free_idx    <= f_idx_c;
                    old_found   <= o_found_c;
                    old_idx     <= o_idx_c;
                    old_age     <= o_age_c;
                    scan_idx    <= scan_idx + IDX_W'(1);
                    if (last_slot) begin
                        if (issue_c) begin
                            o_slot_idx  <= sel_c;
                            o_slot_data <= cmd_q;
                        end
                        o_drop <= drop_c;
                    end
                end
                ISSUE: begin
                    if (i_slot_ready) begin
                        if (o_slot_data[15]) begin
                            // LRU rank: chosen slot becomes youngest; slots younger
                            // than its old rank (or every active slot when freshly
                            // allocated) age by one, saturating.
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if ((IDX_W'(i) != o_slot_idx) && gate_tab[i] &&
                                    (sel_new || (age_tab[i] < sel_age)) &&
                                    (age_tab[i] != AGE_MAX))
                                    age_tab[i] <= age_tab[i] + IDX_W'(1);
                            end
                            age_tab[o_slot_idx]  <= '0;
                            gate_tab[o_slot_idx] <= 1'b1;
                            note_tab[o_slot_idx] <= o_slot_data[6:0];
                        end else begin
                            gate_tab[o_slot_idx] <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 8, number of generator slots (power of two, 2..16).
REQ-002 SHALL have parameter IDX_W, default 3, equal to log2(NUM_VOICES).
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_cmd_valid, input, 1, command present.
REQ-006 SHALL have port i_cmd_data, input, 16, command word: [15] 1=note-on/0=note-off, [13:7] velocity, [6:0] note.
REQ-007 SHALL have port o_cmd_ready, output, 1, command accepted when high with i_cmd_valid.
REQ-008 SHALL have port o_slot_valid, output, 1, slot command to the bank manager valid.
REQ-009 SHALL have port i_slot_ready, input, 1, bank manager accepts the slot command.
REQ-010 SHALL have port o_slot_idx, output, IDX_W, target slot.
REQ-011 SHALL have port o_slot_data, output, 16, {gate, velocity, note} in the same field layout as i_cmd_data.
REQ-012 SHALL have port o_active, output, NUM_VOICES, per-slot gate-on mask.
REQ-013 SHALL have port o_drop, output, 1, one-cycle pulse when a note-on is discarded.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, ISSUE; o_cmd_ready = 1 only in IDLE.
REQ-015 SHALL, on i_cmd_valid && o_cmd_ready, latch i_cmd_data and go IDLE->SCAN; scan index starts at 0.
REQ-016 SHALL examine one slot per cycle in SCAN (exactly NUM_VOICES cycles), recording first matching-note active slot, first free slot (lowest index), and oldest active slot (highest age, lowest index on tie).
REQ-017 SHALL select for note-on: match (retrigger) > free slot > steal oldest.
REQ-018 SHALL select for note-off: first matching active slot; if none, return SCAN->IDLE without ISSUE or o_drop.
REQ-019 SHALL, in ISSUE, assert o_slot_valid with stable idx/data until the cycle i_slot_ready is high, then go to IDLE; latency accept->o_slot_valid = NUM_VOICES+1 cycles.
REQ-020 SHALL update slot tables (note, gate, age) on the ISSUE handshake cycle, not earlier.
REQ-021 SHALL track per-slot age as LRU rank, width IDX_W: on note-on allocation the chosen slot's age = 0 and every active slot with age lower than the chosen slot's previous age (or all active slots if newly allocated) increments, saturating at NUM_VOICES-1.
REQ-022 SHALL clear the slot's gate on note-off handshake; age unchanged; o_active reflects gates registered.
REQ-023 SHALL ignore i_cmd_valid outside IDLE (no queuing); i_slot_ready outside ISSUE has no effect.

Reset
REQ-024 SHALL, while n_rst low, asynchronously force state IDLE, scan index 0, all gates/ages/notes 0, o_slot_valid 0, o_slot_idx 0, o_slot_data 0, o_active 0, o_drop 0; o_cmd_ready 1.
REQ-025 SHALL abort any SCAN/ISSUE in progress on reset with no slot-table update.

Configuration
REQ-026 SHALL honour macro VOICE_STEAL_EN: defined -> full note-on with no match/free slot steals oldest slot (REQ-017); undefined -> such note-on returns to IDLE without ISSUE and pulses o_drop for one cycle at SCAN exit.

Verification (NUM_VOICES=4, i_slot_ready=1 unless stated)
REQ-027 SHALL cover: reset, then note-on 0x8000|note 60 -> o_slot_valid high 5 cycles after accept, idx 0, data gate=1 note 60; o_active=4'b0001.
REQ-028 SHALL cover: note-on 60,62,64,67 then note-on 72 with VOICE_STEAL_EN -> idx 0 (oldest) reused, note 72; without macro -> no o_slot_valid, one o_drop pulse, o_active=4'b1111.
REQ-029 SHALL cover: note-on 60 twice -> both issue idx 0 (retrigger), o_active=4'b0001; then note-off 60 -> idx 0 gate=0, o_active=0.
REQ-030 SHALL cover: note-off 50 with no active note 50 -> no o_slot_valid, no o_drop, o_cmd_ready high again 5 cycles after accept.
REQ-031 SHALL cover: i_slot_ready held low 10 cycles in ISSUE -> o_slot_valid, idx, data stable for all 10 cycles, o_cmd_ready low, extra i_cmd_valid ignored.
REQ-032 SHALL cover: n_rst asserted mid-SCAN -> all outputs at reset values immediately, o_active=0 after release.
